ada_rx_ctrl: RTL
================

# ada_rx_ctrl

Capture controller for the ADA audio input (I2S-style PDM-less MEMS microphone) behind the ada_* pads of the I/O ring. It generates the serial bit clock, word select and L/R-select strobes, samples the serial data line, assembles one channel's samples into words and buffers them in a small FIFO. Software and DMA pop the FIFO through a valid/ready interface. The block sits between the peripheral bus wrapper and the ioring ada_* ports.

## Interface
- CLK_DIV, 8: clk cycles per ada_sck half-period; legal range 4..255.
- SAMPLE_BITS, 24: captured bits per sample, MSB-first; legal range 1..32.
- FIFO_DEPTH, 8: sample FIFO entries; power of two, at least 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = capture running; 0 = stopped, pads idle.
- lr_sel  in  1  channel to capture (0 = left/ws low, 1 = right/ws high); sampled only while enable = 0.
- ada_sck  out  1  bit clock to pad, registered.
- ada_ws  out  1  word select to pad, registered.
- ada_lrs  out  1  microphone L/R select to pad, registered.
- ada_sd  in  1  serial data from pad, asynchronous to clk.
- rx_data  out  SAMPLE_BITS  FIFO head sample.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  pop FIFO head when rx_valid = 1.
- fifo_level  out  clog2(FIFO_DEPTH+1)  current entry count.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.

## Operation
- Reset values: ada_sck = 0, ada_ws = 0, ada_lrs = 0, ovf = 0, FIFO empty (rx_valid = 0, fifo_level = 0), div_cnt = 0, bit_cnt = 0, shift register = 0.
- ada_sd passes through a 2-flop synchronizer (sd_s). CLK_DIV >= 4 guarantees that sd_s is stable at the sample point.
- While enable = 0:
  - div_cnt, bit_cnt and the shift register are held at 0.
  - ada_sck = 0 and ada_ws = 0.
  - ada_lrs <= lr_sel every cycle.
  - The FIFO contents and ovf are retained, and pops remain allowed.
- While enable = 1:
  - div_cnt counts 0..CLK_DIV-1 and wraps. When div_cnt = CLK_DIV-1, ada_sck toggles. This is the rise event if ada_sck = 0 and the fall event if ada_sck = 1.
  - On each fall event, bit_cnt (6-bit) increments mod 64.
  - On each fall event, ada_ws <= new bit_cnt[5].
  - A frame is 64 sck periods: 32 left slots, then 32 right slots.
  - ada_lrs and the captured channel are frozen while enabled.
- Capture on each rise event:
  - Slot position s = (bit_cnt − 1) mod 64, giving the I2S one-bit delay.
  - ch = s[5]; bit = s[4:0], where bit 0 is the slot MSB.
  - If ch = lr_sel and bit < SAMPLE_BITS: shift <= {shift, sd_s}.
  - If, in addition, bit = SAMPLE_BITS-1: the word {shift[SAMPLE_BITS-2:0], sd_s} is pushed into the FIFO on the same edge.
- Enable deasserted mid-frame: stop immediately and discard the partial sample. The next enable restarts at bit_cnt = 0, so the first rise lands in s = 63 (right slot, ignored).
- FIFO behaviour:
  - A pop occurs when rx_valid & rx_ready.
  - Push when full without a simultaneous pop: the sample is dropped, ovf <= 1, and the contents are unchanged.
  - Push and pop in the same cycle when full: both take effect, fifo_level is unchanged, and ovf is not set.
  - Push and pop in the same cycle when empty: the push is accepted and no pop occurs (rx_valid was 0).
  - Pointers wrap mod FIFO_DEPTH.
- ovf priority: a set in the same cycle as ovf_clr wins, so ovf = 1 afterwards.
- rst during operation returns every register to its reset value in the next cycle, including the FIFO (emptied) and ovf.

## Timing
- With enable rising at edge E, the first ada_sck rise is registered at edge E+CLK_DIV.
- sck period is 2·CLK_DIV clk cycles. Frame rate is clk / (128·CLK_DIV).
- ada_ws changes only coincident with an ada_sck fall.
- Sample latency: rx_valid and fifo_level update on the clock edge of the push, one cycle after the last-bit rise event cycle. rx_data is valid in that same cycle.
- rx_data/rx_valid reflect the next entry one cycle after a pop.
- ovf asserts on the edge of the dropped push.

## Test plan
- Default parameters, lr_sel = 0, bench mic drives left slot 0xA5C3F1 MSB-first per I2S timing:
  - One frame later, rx_data = 0xA5C3F1 and fifo_level = 1.
  - The ada_sck period is 16 clk and ada_ws toggles every 32 sck.
- lr_sel = 1, left = 0x111111, right = 0x7FFFFF: only 0x7FFFFF is captured, and ada_lrs = 1.
- rx_ready = 0 for 9 frames: fifo_level saturates at 8 and ovf = 1 after the 9th sample. The FIFO holds the first 8 samples in order. Pulsing ovf_clr then clears ovf.
- FIFO full, with a push and pop in the same cycle: fifo_level stays 8, ovf stays 0, and the oldest sample is popped.
- Drop enable at s = 10 of the captured slot, then re-enable:
  - No partial word is pushed.
  - ada_sck = 0 and ada_ws = 0 while disabled.
  - The next complete sample is captured correctly.
- Assert rst mid-frame with 3 samples queued: the next cycle shows all outputs at reset values and fifo_level = 0.

Source files
------------

// File: rtl/ada_rx_ctrl_if.sv
// Sample delivery port of the ADA capture controller: FIFO head plus
// valid/ready pop handshake towards the bus wrapper / DMA.
interface ada_rx_ctrl_if #(
  parameter int SAMPLE_BITS = 24
);
  logic [SAMPLE_BITS-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;

  // Capture controller side drives data/valid, consumer drives ready.
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ada_rx_ctrl.sv
// ADA audio input capture controller: generates I2S bit clock / word select,
// samples one channel MSB-first with the I2S one-bit delay and buffers the
// assembled samples in a small FIFO popped through a valid/ready port.
module ada_rx_ctrl #(
  parameter int CLK_DIV     = 8,
  parameter int SAMPLE_BITS = 24,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               lr_sel,
  output logic                               ada_sck,
  output logic                               ada_ws,
  output logic                               ada_lrs,
  input  logic                               ada_sd,
  ada_rx_ctrl_if.master                      rx_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               ovf,
  input  logic                               ovf_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  // Serial data synchronizer.
  logic                   sd_meta_q, sd_s_q;
  // Bit clock / frame generation.
  logic [7:0]             div_cnt_q, div_cnt_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic                   lrs_q, lrs_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  // Sample FIFO.
  logic [SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ovf_q, ovf_d;

  logic                   tick, rise, fall, capture, push, pop, full, wr_en;
  logic [5:0]             slot;
  logic [SAMPLE_BITS-1:0] sample_word;

  // Edge events of the bit clock and capture decision for the current slot.
  always_comb begin
    tick        = enable && (div_cnt_q == 8'(CLK_DIV - 1));
    rise        = tick && !sck_q;
    fall        = tick && sck_q;
    // One-bit I2S delay: the rise after fall number n samples slot bit n-1.
    slot        = bit_cnt_q - 6'd1;
    sample_word = SAMPLE_BITS'({shift_q, sd_s_q});
    capture     = rise && (slot[5] == lrs_q) && (int'(slot[4:0]) < SAMPLE_BITS);
    push        = capture && (int'(slot[4:0]) == SAMPLE_BITS - 1);
  end

  // Next state of the bit clock, word select, L/R select and shift register.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    lrs_d     = lrs_q;
    shift_d   = shift_q;
    if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      sck_d     = 1'b0;
      ws_d      = 1'b0;
      lrs_d     = lr_sel;
      shift_d   = '0;
    end else begin
      div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
      if (tick) sck_d = !sck_q;
      if (fall) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        // NOTE: blocking assignments in always_comb, so ws_d sees the new bit_cnt_d.
        ws_d      = bit_cnt_d[5];
      end
      if (capture) shift_d = sample_word;
    end
  end

  // FIFO pointer, level and overflow bookkeeping.
  always_comb begin
    pop      = (level_q != '0) && rx_if.rx_ready;
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    // A dropped push in the same cycle as a clear leaves the flag set.
    ovf_d    = (ovf_q && !ovf_clr) || (push && !wr_en);
  end

  // All control state, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_meta_q <= 1'b0;
      sd_s_q    <= 1'b0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      lrs_q     <= 1'b0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
      sd_meta_q <= ada_sd;
      sd_s_q    <= sd_meta_q;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      lrs_q     <= lrs_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  // Sample storage written on accepted pushes.
  // NOTE: storage is not reset; emptiness is tracked by the pointers and level only.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sample_word;
  end

  assign ada_sck        = sck_q;
  assign ada_ws         = ws_q;
  assign ada_lrs        = lrs_q;
  assign rx_if.rx_data  = mem_q[rd_ptr_q];
  assign rx_if.rx_valid = (level_q != '0);
  assign fifo_level     = level_q;
  assign ovf            = ovf_q;

endmodule
